data_mem_arbiter: RTL

Two-master arbiter that shares the single-port `Data_Memory` between the CPU load/store path (master 0) and a second bus master (master 1, e.g. loader/DMA or display scanner). Sits between the masters and `Data_Memory` in `Gambling_Tec`. Drives the memory's `we/a/wd` and returns `rd` to the owning master. Ownership is registered and round-robin, with a bounded hold so that neither master starves.

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_select.sv | 14 +
 rtl/data_mem_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the data-memory arbiter.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_t;

  localparam int DEF_ADDR_W   = 32;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_MAX_HOLD = 4;

  // Ownership state for a given master index.
  function automatic arb_state_t own_state(input logic idx);
    return idx ? OWN1 : OWN0;
  endfunction

endpackage

// File: rtl/rr_select.sv
// Two-way round-robin pick: a lone requester wins, a tie goes to the preferred master.
module rr_select (
  input  logic [1:0] req,
  input  logic       rr,
  output logic       valid,
  output logic       winner
);

  always_comb begin
    valid  = |req;
    winner = (req == 2'b11) ? rr : req[1];
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Shares one single-port data memory between two masters with registered
// round-robin ownership and a bounded hold so neither side starves.
import mem_arb_pkg::*;

module data_mem_arbiter #(
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              m0_req,
  input  logic              m1_req,
  input  logic              m0_we,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m0_gnt,
  output logic              m1_gnt,
  output logic [DATA_W-1:0] m0_rdata,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m0_rvalid,
  output logic              m1_rvalid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_a,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd
);

  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW:0] HOLD_LIM = (HW + 1)'(MAX_HOLD);

  arb_state_t    state;
  logic          rr;
  logic [HW-1:0] hold;

  logic          own_idx;
  logic          own_req;
  logic          oth_req;
  logic [HW:0]   hold_inc;
  logic          at_limit;
  logic [HW-1:0] hold_sat;
  logic          sel_valid;
  logic          sel_winner;

  assign m0_gnt = (state == OWN0) && m0_req;
  assign m1_gnt = (state == OWN1) && m1_req;

  assign own_idx = (state == OWN1);
  assign own_req = own_idx ? m1_req : m0_req;
  assign oth_req = own_idx ? m0_req : m1_req;

  // Counting the accept happening on this edge decides whether the owner must yield.
  assign hold_inc = {1'b0, hold} + (HW + 1)'(1);
  assign at_limit = (hold_inc >= HOLD_LIM);
  assign hold_sat = (hold_inc > HOLD_LIM) ? HOLD_LIM[HW-1:0] : hold_inc[HW-1:0];

  rr_select u_rr_select (
    .req    ({m1_req, m0_req}),
    .rr     (rr),
    .valid  (sel_valid),
    .winner (sel_winner)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      rr    <= 1'b0;
      hold  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_valid) begin
            state <= own_state(sel_winner);
            rr    <= ~sel_winner;
            hold  <= '0;
          end
        end
        OWN0, OWN1: begin
          if (own_req && !(oth_req && at_limit)) begin
            hold <= hold_sat;
          end else if (oth_req) begin
            state <= own_state(~own_idx);
            rr    <= own_idx;
            hold  <= '0;
          end else begin
            state <= IDLE;
            hold  <= '0;
          end
        end
        default: begin
          state <= IDLE;
          hold  <= '0;
        end
      endcase
    end
  end

  always_comb begin
    mem_we = 1'b0;
    mem_a  = '0;
    mem_wd = '0;
    if (m0_gnt) begin
      mem_we = m0_we;
      mem_a  = m0_addr;
      mem_wd = m0_wdata;
    end else if (m1_gnt) begin
      mem_we = m1_we;
      mem_a  = m1_addr;
      mem_wd = m1_wdata;
    end
  end

  logic [1:0]        gnt_v;
  logic [1:0]        we_v;
  logic              rvalid_r [2];
  logic [DATA_W-1:0] rdata_r  [2];

  assign gnt_v = {m1_gnt, m0_gnt};
  assign we_v  = {m1_we, m0_we};

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_ret
      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          rvalid_r[gi] <= 1'b0;
          rdata_r[gi]  <= '0;
        end else begin
          rvalid_r[gi] <= gnt_v[gi] && !we_v[gi];
          if (gnt_v[gi] && !we_v[gi]) begin
            rdata_r[gi] <= mem_rd;
          end
        end
      end
    end
  endgenerate

  assign m0_rvalid = rvalid_r[0];
  assign m1_rvalid = rvalid_r[1];
  assign m0_rdata  = rdata_r[0];
  assign m1_rdata  = rdata_r[1];

endmodule
